// File: rtl/fb_scanout.sv
// fb_scanout: 640x480 VGA scan-out of a 320x240 3-bit frame buffer with 2x
// pixel and line doubling; sync and colour travel a 3-stage aligned pipeline.
module fb_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [16:0] fb_rd_addr,
  output logic        fb_rd_en,
  input  logic        fb_red,
  input  logic        fb_green,
  input  logic        fb_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_red,
  output logic        vga_green,
  output logic        vga_blue,
  output logic        vblank,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        running;
  logic        h_end;
  logic        frame_end;
  logic        visible;
  logic        hsync_raw;
  logic        vsync_raw;
  logic [8:0]  fb_x;
  logic [8:0]  fb_y;
  logic [16:0] addr_next;

  // Stage 1 and stage 2 of the flag delay; the pin registers are stage 3.
  logic [1:0]  vis_d;
  logic [1:0]  hs_d;
  logic [1:0]  vs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    running     = (state == RUN);
    h_end       = (h_cnt == H_LAST);
    frame_end   = h_end && (v_cnt == V_LAST);
    vblank      = !running || (v_cnt >= V_ACT);
    frame_start = running && (h_cnt == '0) && (v_cnt == '0);
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN:  if (frame_end && !enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (running) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // y*320 + x built from shifts; the sum never exceeds 76799.
  always_comb begin
    fb_x      = h_cnt[9:1];
    fb_y      = v_cnt[9:1];
    addr_next = {fb_y, 8'd0} + {2'd0, fb_y, 6'd0} + {8'd0, fb_x};
    visible   = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_raw = !(running && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vsync_raw = !(running && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_rd_en   <= 1'b0;
      fb_rd_addr <= '0;
      vis_d      <= '0;
      hs_d       <= '1;
      vs_d       <= '1;
      vga_hsync  <= 1'b1;
      vga_vsync  <= 1'b1;
      vga_red    <= 1'b0;
      vga_green  <= 1'b0;
      vga_blue   <= 1'b0;
    end else begin
      fb_rd_en   <= visible;
      fb_rd_addr <= visible ? addr_next : '0;
      vis_d      <= {vis_d[0], visible};
      hs_d       <= {hs_d[0], hsync_raw};
      vs_d       <= {vs_d[0], vsync_raw};
      vga_hsync  <= hs_d[1];
      vga_vsync  <= vs_d[1];
      vga_red    <= vis_d[1] & fb_red;
      vga_green  <= vis_d[1] & fb_green;
      vga_blue   <= vis_d[1] & fb_blue;
    end
  end

endmodule
